// File: rtl/gpio_banked_if.sv
// Register bus between the core and the banked GPIO block.
// The read-data wire is named dout because "do" is a reserved word.
interface gpio_banked_if #(
  parameter int REGSEL_W = 4
);
  logic [REGSEL_W-1:0] regSel;
  logic                we;
  logic [31:0]         di;
  logic [31:0]         dout;
  logic                irq;

  modport master (
    output regSel, we, di,
    input  dout, irq
  );

  modport slave (
    input  regSel, we, di,
    output dout, irq
  );
endinterface

// File: rtl/gpio_banked.sv
// Banked tri-state GPIO: NUM_PORTS ports of PORT_W pins with direction, set/clear,
// two-flop input synchroniser and sticky W1C edge-interrupt status per pin.
module gpio_banked #(
  parameter int PORT_W    = 8,
  parameter int NUM_PORTS = 2,
  parameter int REGSEL_W  = $clog2(NUM_PORTS) + 3
) (
  input  logic                          clk,
  input  logic                          reset,
  gpio_banked_if.slave                  bus,
  inout  wire [NUM_PORTS*PORT_W-1:0]    ports
);

  typedef logic [PORT_W-1:0] pin_t;

  localparam logic [31:0] NP_U = 32'(NUM_PORTS);

  pin_t wr_q   [NUM_PORTS];
  pin_t wr_d   [NUM_PORTS];
  pin_t dir_q  [NUM_PORTS];
  pin_t dir_d  [NUM_PORTS];
  pin_t rise_q [NUM_PORTS];
  pin_t rise_d [NUM_PORTS];
  pin_t fall_q [NUM_PORTS];
  pin_t fall_d [NUM_PORTS];
  pin_t stat_q [NUM_PORTS];
  pin_t stat_d [NUM_PORTS];
  pin_t s1_q   [NUM_PORTS];
  pin_t s1_d   [NUM_PORTS];
  pin_t s2_q   [NUM_PORTS];
  pin_t s2_d   [NUM_PORTS];
  pin_t prev_q [NUM_PORTS];
  pin_t prev_d [NUM_PORTS];

  pin_t pad_in [NUM_PORTS];
  pin_t ev     [NUM_PORTS];

  logic [31:0] port_idx;
  logic [2:0]  offs;
  logic        hit;
  pin_t        wdata;
  pin_t        rdata;
  logic        irq_any;
  logic        unused_di;

  // A wider regSel than the port count needs simply decodes to no port.
  assign port_idx  = 32'(bus.regSel >> 3);
  assign offs      = bus.regSel[2:0];
  assign hit       = (port_idx < NP_U);
  assign wdata     = bus.di[PORT_W-1:0];
  assign unused_di = ^bus.di;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar i = 0; i < PORT_W; i++) begin : g_pin
      assign ports[p*PORT_W + i] = dir_q[p][i] ? wr_q[p][i] : 1'bz;
    end
    // Output pins are sampled too, so self-driven edges can raise status.
    assign pad_in[p] = ports[p*PORT_W +: PORT_W];
    assign ev[p]     = (s2_q[p] & ~prev_q[p] & rise_q[p]) |
                       (~s2_q[p] & prev_q[p] & fall_q[p]);
  end

  always_comb begin
    logic wsel;
    pin_t w1c;
    wsel = 1'b0;
    w1c  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_d[p]   = wr_q[p];
      dir_d[p]  = dir_q[p];
      rise_d[p] = rise_q[p];
      fall_d[p] = fall_q[p];
      s1_d[p]   = pad_in[p];
      s2_d[p]   = s1_q[p];
      prev_d[p] = s2_q[p];
      w1c       = '0;
      wsel      = bus.we && hit && (port_idx == 32'(p));
      if (wsel) begin
        case (offs)
          3'd0:    wr_d[p]   = wdata;
          3'd1:    dir_d[p]  = wdata;
          3'd3:    wr_d[p]   = wr_q[p] | wdata;
          3'd4:    wr_d[p]   = wr_q[p] & ~wdata;
          3'd5:    rise_d[p] = wdata;
          3'd6:    fall_d[p] = wdata;
          3'd7:    w1c       = wdata;
          default: ;
        endcase
      end
      // A new event in the same cycle as a clear keeps the bit set.
      stat_d[p] = (stat_q[p] & ~w1c) | ev[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_q[p]   <= '0;
        dir_q[p]  <= '0;
        rise_q[p] <= '0;
        fall_q[p] <= '0;
        stat_q[p] <= '0;
        s1_q[p]   <= '0;
        s2_q[p]   <= '0;
        prev_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_q[p]   <= wr_d[p];
        dir_q[p]  <= dir_d[p];
        rise_q[p] <= rise_d[p];
        fall_q[p] <= fall_d[p];
        stat_q[p] <= stat_d[p];
        s1_q[p]   <= s1_d[p];
        s2_q[p]   <= s2_d[p];
        prev_q[p] <= prev_d[p];
      end
    end
  end

  always_comb begin
    rdata   = '0;
    irq_any = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      irq_any = irq_any | (|stat_q[p]);
      if (hit && (port_idx == 32'(p))) begin
        case (offs)
          3'd0:    rdata = wr_q[p];
          3'd1:    rdata = dir_q[p];
          3'd2:    rdata = s2_q[p];
          3'd5:    rdata = rise_q[p];
          3'd6:    rdata = fall_q[p];
          3'd7:    rdata = stat_q[p];
          default: rdata = '0;
        endcase
      end
    end
  end

  assign bus.dout = 32'(rdata);
  assign bus.irq  = irq_any;

endmodule

// File: tb/tb_gpio_banked.sv
// Directed bench for gpio_banked with two 8-bit ports; undriven pads are pulled
// up so a released (Z) pad reads as 1.
module tb_gpio_banked;
  logic        clk;
  logic        reset;
  wire  [15:0] ports;
  logic [15:0] tb_en;
  logic [15:0] tb_val;
  int          errors;
  int          checks;

  gpio_banked_if #(.REGSEL_W(5)) bus ();

  gpio_banked #(.PORT_W(8), .NUM_PORTS(2), .REGSEL_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ports (ports)
  );

  for (genvar i = 0; i < 16; i++) begin : g_pad
    pullup pu (ports[i]);
    assign ports[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.regSel = a;
    #1;
    chk(tag, bus.dout, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.regSel = a;
    bus.di     = d;
    bus.we     = 1'b1;
    @(negedge clk);
    bus.we     = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    bus.regSel = '0;
    bus.we     = 1'b0;
    bus.di     = '0;
    tb_en      = '0;
    tb_val     = '0;
    cyc(3);
    reset = 1'b1;

    // Reset state
    rchk(5'b00000, 32'h0, "rst_wr_a");
    rchk(5'b00001, 32'h0, "rst_dir_a");
    rchk(5'b00101, 32'h0, "rst_rise_a");
    rchk(5'b00110, 32'h0, "rst_fall_a");
    rchk(5'b00111, 32'h0, "rst_stat_a");
    rchk(5'b01000, 32'h0, "rst_wr_b");
    rchk(5'b01001, 32'h0, "rst_dir_b");
    rchk(5'b01101, 32'h0, "rst_rise_b");
    rchk(5'b01110, 32'h0, "rst_fall_b");
    rchk(5'b01111, 32'h0, "rst_stat_b");
    chk("rst_pads_z", {16'h0, ports}, 32'h0000FFFF);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);

    // Output path: A5 | 0A = AF, AF & ~81 = 2E
    wr(5'b00000, 32'hA5);
    wr(5'b00001, 32'hFF);
    wr(5'b00011, 32'h0A);
    rchk(5'b00000, 32'hAF, "wr_set_a");
    wr(5'b00100, 32'h81);
    rchk(5'b00000, 32'h2E, "wr_clr_a");
    rchk(5'b00011, 32'h0, "wr_set_reads0");
    rchk(5'b00100, 32'h0, "wr_clr_reads0");
    chk("pads_a_drive", {24'h0, ports[7:0]}, 32'h2E);
    chk("pads_b_z", {24'h0, ports[15:8]}, 32'hFF);
    wr(5'b00010, 32'h55);
    rchk(5'b00000, 32'h2E, "rd_write_ignored");
    cyc(2);
    rchk(5'b00010, 32'h2E, "rd_a_self");

    // Input synchroniser latency on port B
    tb_en  = 16'hFF00;
    tb_val = 16'h0000;
    cyc(3);
    rchk(5'b01010, 32'h00, "rd_b_base");
    tb_val = 16'h3C00;
    cyc(1);
    rchk(5'b01010, 32'h00, "rd_b_k");
    cyc(1);
    rchk(5'b01010, 32'h3C, "rd_b_k1");
    rchk(5'b01111, 32'h0, "stat_b_no_en");

    // Edge interrupts: pin 8 rise, pin 15 fall
    wr(5'b01101, 32'h01);
    wr(5'b01110, 32'h80);
    tb_val = 16'hBC00;
    cyc(3);
    rchk(5'b01111, 32'h0, "stat_b_unen_rise");
    tb_val = 16'h3D00;
    cyc(1);
    rchk(5'b01111, 32'h00, "stat_b_k");
    cyc(1);
    rchk(5'b01111, 32'h00, "stat_b_k1");
    chk("irq_k1", {31'h0, bus.irq}, 32'h0);
    cyc(1);
    rchk(5'b01111, 32'h81, "stat_b_k2");
    chk("irq_k2", {31'h0, bus.irq}, 32'h1);
    wr(5'b01111, 32'h01);
    rchk(5'b01111, 32'h80, "w1c_bit0");
    chk("irq_after_w1c0", {31'h0, bus.irq}, 32'h1);
    wr(5'b01111, 32'h80);
    rchk(5'b01111, 32'h00, "w1c_bit7");
    chk("irq_cleared", {31'h0, bus.irq}, 32'h0);

    // Same-cycle clear and event: bit 7 clears, bit 0 set wins
    tb_val = 16'h3C00;
    cyc(3);
    tb_val = 16'hBC00;
    cyc(3);
    tb_val = 16'h3C00;
    cyc(3);
    rchk(5'b01111, 32'h80, "stat_b_pre");
    tb_val = 16'h3D00;
    cyc(2);
    wr(5'b01111, 32'h81);
    rchk(5'b01111, 32'h01, "set_wins");
    chk("irq_set_wins", {31'h0, bus.irq}, 32'h1);
    wr(5'b01111, 32'h01);
    rchk(5'b01111, 32'h00, "w1c_after_set");

    // Unimplemented port index
    wr(5'b10000, 32'hFF);
    rchk(5'b10000, 32'h0, "unimpl_read");
    rchk(5'b10001, 32'h0, "unimpl_dir_read");
    rchk(5'b00000, 32'h2E, "unimpl_no_wr_a");
    rchk(5'b01000, 32'h00, "unimpl_no_wr_b");
    chk("unimpl_pads", {16'h0, ports}, 32'h00003D2E);

    // Reset with pending status
    tb_val = 16'h3C00;
    cyc(3);
    tb_val = 16'h3D00;
    cyc(3);
    rchk(5'b01111, 32'h01, "pending_stat");
    chk("pending_irq", {31'h0, bus.irq}, 32'h1);
    reset = 1'b0;
    cyc(1);
    rchk(5'b01111, 32'h00, "mid_rst_stat");
    chk("mid_rst_irq", {31'h0, bus.irq}, 32'h0);
    rchk(5'b00000, 32'h00, "mid_rst_wr_a");
    rchk(5'b01101, 32'h00, "mid_rst_rise_b");
    chk("mid_rst_pads_a_z", {24'h0, ports[7:0]}, 32'hFF);
    reset = 1'b1;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
